// File: rtl/mem_port_scheduler_if.sv
// Bundle of requester-side handshake signals and memory-side port buses
// that connect the scheduler to its clients and to the 2R1W memory.
interface mem_port_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int ADDRW = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ*WIDTH-1:0] rsp_rdata;
    logic [1:0]            mem_rd_ens;
    logic [2*ADDRW-1:0]    mem_rd_addrs;
    logic [2*WIDTH-1:0]    mem_rd_datas;
    logic                  mem_wr_en;
    logic                  mem_wr_mask;
    logic [ADDRW-1:0]      mem_wr_addr;
    logic [WIDTH-1:0]      mem_wr_data;

    // Parent side: the clients plus the memory instance.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rd_datas,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_rd_ens, mem_rd_addrs, mem_wr_en, mem_wr_mask, mem_wr_addr, mem_wr_data
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rd_datas,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_rd_ens, mem_rd_addrs, mem_wr_en, mem_wr_mask, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler sharing one 2R1W combinational-read memory among
// NREQ requesters: up to two reads and one write granted per cycle, read
// data returned to the requester one cycle after acceptance.
module mem_port_scheduler #(
    parameter int NREQ  = 4,
    parameter int ADDRW = 4,
    parameter int WIDTH = 8
) (
    input logic                clock,
    input logic                reset,
    mem_port_scheduler_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_scan;
    logic [PW-1:0]         rd_scan;
    logic [PW-1:0]         wr_idx;
    logic [PW-1:0]         rd_idx0;
    logic [PW-1:0]         rd_idx1;
    logic                  wr_hit;
    logic                  rd_hit0;
    logic                  rd_hit1;
    logic [NREQ-1:0]       act_wr;
    logic [NREQ-1:0]       act_rd;
    logic [NREQ-1:0]       wr_gnt;
    logic [NREQ-1:0]       rd_gnt0;
    logic [NREQ-1:0]       rd_gnt1;
    logic [NREQ-1:0]       rsp_valid_q;
    logic [NREQ*WIDTH-1:0] rsp_rdata_q;

    // Cyclic increment; NREQ need not be a power of two.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] v);
        if (int'(v) >= NREQ - 1) begin
            return '0;
        end
        return v + PW'(1);
    endfunction

    // Requests are masked during reset so nothing can be granted or accepted.
    assign act_wr = reset ? '0 : (bus.req_valid & bus.req_write);
    assign act_rd = reset ? '0 : (bus.req_valid & ~bus.req_write);

    // Write arbiter: first active write found scanning cyclically from wr_ptr.
    always_comb begin
        wr_hit  = 1'b0;
        wr_idx  = '0;
        wr_scan = wr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!wr_hit && act_wr[wr_scan]) begin
                wr_hit = 1'b1;
                wr_idx = wr_scan;
            end
            wr_scan = next_idx(wr_scan);
        end
    end

    // Read arbiter: first two active reads from rd_ptr go to ports 0 and 1.
    always_comb begin
        rd_hit0 = 1'b0;
        rd_hit1 = 1'b0;
        rd_idx0 = '0;
        rd_idx1 = '0;
        rd_scan = rd_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (act_rd[rd_scan]) begin
                if (!rd_hit0) begin
                    rd_hit0 = 1'b1;
                    rd_idx0 = rd_scan;
                end else if (!rd_hit1) begin
                    rd_hit1 = 1'b1;
                    rd_idx1 = rd_scan;
                end
            end
            rd_scan = next_idx(rd_scan);
        end
    end

    // One-hot grant vectors per port; a requester holds one request, so
    // the three vectors never overlap.
    always_comb begin
        wr_gnt  = '0;
        rd_gnt0 = '0;
        rd_gnt1 = '0;
        if (wr_hit) begin
            wr_gnt[wr_idx] = 1'b1;
        end
        if (rd_hit0) begin
            rd_gnt0[rd_idx0] = 1'b1;
        end
        if (rd_hit1) begin
            rd_gnt1[rd_idx1] = 1'b1;
        end
    end

    assign bus.req_ready = wr_gnt | rd_gnt0 | rd_gnt1;

    // Memory port drive; idle ports present zero address and data.
    always_comb begin
        bus.mem_rd_ens   = {rd_hit1, rd_hit0};
        bus.mem_rd_addrs = '0;
        bus.mem_wr_en    = wr_hit;
        bus.mem_wr_mask  = wr_hit;
        bus.mem_wr_addr  = '0;
        bus.mem_wr_data  = '0;
        if (rd_hit0) begin
            bus.mem_rd_addrs[0 +: ADDRW] = bus.req_addr[rd_idx0*ADDRW +: ADDRW];
        end
        if (rd_hit1) begin
            bus.mem_rd_addrs[ADDRW +: ADDRW] = bus.req_addr[rd_idx1*ADDRW +: ADDRW];
        end
        if (wr_hit) begin
            bus.mem_wr_addr = bus.req_addr[wr_idx*ADDRW +: ADDRW];
            bus.mem_wr_data = bus.req_wdata[wr_idx*WIDTH +: WIDTH];
        end
    end

    // Pointers move just past the last requester granted in each class.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_hit) begin
                wr_ptr <= next_idx(wr_idx);
            end
            if (rd_hit1) begin
                rd_ptr <= next_idx(rd_idx1);
            end else if (rd_hit0) begin
                rd_ptr <= next_idx(rd_idx0);
            end
        end
    end

    // Capture read data at the end of the accept cycle; the slice holds
    // until that requester's next response.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                rsp_valid_q[i] <= rd_gnt0[i] | rd_gnt1[i];
                if (rd_gnt0[i]) begin
                    rsp_rdata_q[i*WIDTH +: WIDTH] <= bus.mem_rd_datas[0 +: WIDTH];
                end else if (rd_gnt1[i]) begin
                    rsp_rdata_q[i*WIDTH +: WIDTH] <= bus.mem_rd_datas[WIDTH +: WIDTH];
                end
            end
        end
    end

    // Responses are suppressed while reset is high, so a read accepted in
    // the cycle before reset never reaches its requester.
    assign bus.rsp_valid = reset ? '0 : rsp_valid_q;
    assign bus.rsp_rdata = reset ? '0 : rsp_rdata_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Bench for mem_port_scheduler with NREQ=4, ADDRW=4, WIDTH=8: directed
// vector table, reset-after-accept sequence, then random mixed traffic
// against a reference memory model.
module tb_mem_port_scheduler;
    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_scheduler_if #(.NREQ(4), .ADDRW(4), .WIDTH(8)) bus ();

    mem_port_scheduler #(.NREQ(4), .ADDRW(4), .WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 2R1W memory with combinational reads, written on the clock edge.
    logic [7:0] mem [16] = '{default: 8'h00};
    assign bus.mem_rd_datas = {mem[bus.mem_rd_addrs[7:4]], mem[bus.mem_rd_addrs[3:0]]};
    always @(posedge clock) begin
        if (bus.mem_wr_en && bus.mem_wr_mask) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  e_ready;
        logic [1:0]  e_rd_ens;
        logic [7:0]  e_rd_addrs;
        logic        e_wr_en;
        logic [3:0]  e_wr_addr;
        logic [7:0]  e_wr_data;
        logic [3:0]  e_rsp_valid;
        logic [31:0] e_rsp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic rst, input string tag);
        @(posedge clock);
        #1;
        reset         = rst;
        bus.req_valid = v.valid;
        bus.req_write = v.write;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(negedge clock);
        check({tag, " req_ready"},    bus.req_ready,    v.e_ready);
        check({tag, " mem_rd_ens"},   bus.mem_rd_ens,   v.e_rd_ens);
        check({tag, " mem_rd_addrs"}, bus.mem_rd_addrs, v.e_rd_addrs);
        check({tag, " mem_wr_en"},    bus.mem_wr_en,    v.e_wr_en);
        check({tag, " mem_wr_mask"},  bus.mem_wr_mask,  v.e_wr_en);
        check({tag, " mem_wr_addr"},  bus.mem_wr_addr,  v.e_wr_addr);
        check({tag, " mem_wr_data"},  bus.mem_wr_data,  v.e_wr_data);
        check({tag, " rsp_valid"},    bus.rsp_valid,    v.e_rsp_valid);
        check({tag, " rsp_rdata"},    bus.rsp_rdata,    v.e_rsp_rdata);
    endtask

    // Random-phase state
    logic [3:0]  r_valid;
    logic [3:0]  r_write;
    logic [3:0]  r_addr [4];
    logic [7:0]  r_wdata [4];
    logic [3:0]  acc;
    logic [3:0]  pend;
    logic [31:0] model_rdata;
    logic [7:0]  ref_mem [16];
    int          rd_wait [4];
    int          wr_wait [4];

    initial begin
        vec_t v_rst;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        //            valid write addr      wdata         rdy  ens  rdad  we wa  wd     rv   rdata
        v_rst     = '{4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h0, 2'h0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 32'h00000000};
        vecs[0]   = '{4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h1, 2'h0, 8'h00, 1'b1, 4'h0, 8'h10, 4'h0, 32'h00000000};
        vecs[1]   = '{4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h2, 2'h0, 8'h00, 1'b1, 4'h1, 8'h11, 4'h0, 32'h00000000};
        vecs[2]   = '{4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h4, 2'h0, 8'h00, 1'b1, 4'h2, 8'h12, 4'h0, 32'h00000000};
        vecs[3]   = '{4'hF, 4'hF, 16'h3210, 32'h13121110, 4'h8, 2'h0, 8'h00, 1'b1, 4'h3, 8'h13, 4'h0, 32'h00000000};
        vecs[4]   = '{4'h8, 4'h0, 16'h2000, 32'h00000000, 4'h8, 2'h1, 8'h02, 1'b0, 4'h0, 8'h00, 4'h0, 32'h00000000};
        vecs[5]   = '{4'hF, 4'h0, 16'h3210, 32'h00000000, 4'h3, 2'h3, 8'h10, 1'b0, 4'h0, 8'h00, 4'h8, 32'h12000000};
        vecs[6]   = '{4'hF, 4'h0, 16'h3210, 32'h00000000, 4'hC, 2'h3, 8'h32, 1'b0, 4'h0, 8'h00, 4'h3, 32'h12001110};
        vecs[7]   = '{4'hF, 4'h0, 16'h3210, 32'h00000000, 4'h3, 2'h3, 8'h10, 1'b0, 4'h0, 8'h00, 4'hC, 32'h13121110};
        vecs[8]   = '{4'h3, 4'h1, 16'h0055, 32'h000000AA, 4'h3, 2'h1, 8'h05, 1'b1, 4'h5, 8'hAA, 4'h3, 32'h13121110};
        vecs[9]   = '{4'h4, 4'h0, 16'h0500, 32'h00000000, 4'h4, 2'h1, 8'h05, 1'b0, 4'h0, 8'h00, 4'h2, 32'h13120010};
        vecs[10]  = '{4'h0, 4'h0, 16'h0000, 32'h00000000, 4'h0, 2'h0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h4, 32'h13AA0010};

        run_vec(v_rst, 1'b1, "reset");
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Requester 1 read accepted, then reset the following cycle.
        run_vec('{4'h2, 4'h0, 16'h0020, 32'h0, 4'h2, 2'h1, 8'h02, 1'b0, 4'h0, 8'h00, 4'h0, 32'h13AA0010},
                1'b0, "rst_seq accept");
        run_vec(v_rst, 1'b1, "rst_seq in_reset");
        // Both pointers must restart at 0: write to req0, reads to reqs 1 and 2.
        run_vec('{4'hF, 4'h1, 16'h2107, 32'h00000077, 4'h7, 2'h3, 8'h10, 1'b1, 4'h7, 8'h77, 4'h0, 32'h00000000},
                1'b0, "rst_seq post");
        run_vec('{4'h0, 4'h0, 16'h0000, 32'h0, 4'h0, 2'h0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h6, 32'h00111000},
                1'b0, "rst_seq resp");

        // Random mixed traffic. Memory contents follow from the writes above.
        for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
        ref_mem[0] = 8'h10;
        ref_mem[1] = 8'h11;
        ref_mem[2] = 8'h12;
        ref_mem[3] = 8'h13;
        ref_mem[5] = 8'hAA;
        ref_mem[7] = 8'h77;
        model_rdata = 32'h00111000;
        pend        = '0;
        r_valid     = '0;
        r_write     = '0;
        acc         = '0;
        for (int i = 0; i < 4; i++) begin
            r_addr[i]  = '0;
            r_wdata[i] = '0;
            rd_wait[i] = 0;
            wr_wait[i] = 0;
        end

        for (int cyc = 0; cyc < 300; cyc++) begin
            int nrd;
            int nwr;
            @(posedge clock);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!r_valid[i] || acc[i]) begin
                    r_valid[i] = ($urandom_range(3) != 0);
                    r_write[i] = ($urandom_range(2) == 0);
                    r_addr[i]  = 4'($urandom_range(15));
                    r_wdata[i] = 8'($urandom_range(255));
                end
                bus.req_addr[i*4 +: 4]  = r_addr[i];
                bus.req_wdata[i*8 +: 8] = r_wdata[i];
            end
            bus.req_valid = r_valid;
            bus.req_write = r_write;
            @(negedge clock);

            check("rand rsp_valid", bus.rsp_valid, pend);
            check("rand rsp_rdata", bus.rsp_rdata, model_rdata);

            acc = bus.req_ready & r_valid;
            check("rand ready_without_valid", bus.req_ready & ~r_valid, 4'h0);
            nrd = $countones(r_valid & ~r_write);
            nwr = $countones(r_valid & r_write);
            check("rand rd_grants", $countones(acc & ~r_write), (nrd > 2) ? 2 : nrd);
            check("rand rd_ens", $countones(bus.mem_rd_ens), (nrd > 2) ? 2 : nrd);
            check("rand wr_grants", $countones(acc & r_write), (nwr > 0) ? 1 : 0);
            check("rand wr_en", bus.mem_wr_en, (nwr > 0) ? 1 : 0);

            for (int i = 0; i < 4; i++) begin
                if (r_valid[i] && !r_write[i]) begin
                    if (acc[i]) rd_wait[i] = 0;
                    else begin
                        rd_wait[i]++;
                        check($sformatf("rand rd_fair req%0d too_late", i), rd_wait[i] > 1, 1'b0);
                    end
                end
                if (r_valid[i] && r_write[i]) begin
                    if (acc[i]) wr_wait[i] = 0;
                    else begin
                        wr_wait[i]++;
                        check($sformatf("rand wr_fair req%0d too_late", i), wr_wait[i] > 3, 1'b0);
                    end
                end
            end

            pend = '0;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && !r_write[i]) begin
                    pend[i] = 1'b1;
                    model_rdata[i*8 +: 8] = ref_mem[r_addr[i]];
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && r_write[i]) ref_mem[r_addr[i]] = r_wdata[i];
            end
        end

        @(posedge clock);
        #1;
        bus.req_valid = '0;
        @(negedge clock);
        check("final rsp_valid", bus.rsp_valid, pend);
        check("final rsp_rdata", bus.rsp_rdata, model_rdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_scheduler.md
# mem_port_scheduler

Round-robin scheduler that shares one two-read/one-write memory (the 2R1W combinational-read `MRMWMEM` configuration) among NREQ requesters. Each cycle it grants up to two reads and one write. It drives the memory's flattened port buses and returns read data to each requester one cycle after acceptance. It sits between the client blocks and the memory instance in the parent module; the parent wires `clock` to all memory port clocks.

## Interface
- NREQ, 4, number of requesters, 2..16
- ADDRW, 4, address width; memory depth is 2^ADDRW
- WIDTH, 8, data width
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  bit i: requester i presents a request
- req_write  in  NREQ  bit i: 1 = write, 0 = read
- req_addr  in  NREQ*ADDRW  slice i = [i*ADDRW +: ADDRW]
- req_wdata  in  NREQ*WIDTH  slice i = [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  bit i: request i granted this cycle (combinational)
- rsp_valid  out  NREQ  bit i: read response for requester i (registered)
- rsp_rdata  out  NREQ*WIDTH  slice i: read data for requester i
- mem_rd_ens  out  2  read port enables; bit 0 = port 0
- mem_rd_addrs  out  2*ADDRW  port p address at [p*ADDRW +: ADDRW]
- mem_rd_datas  in  2*WIDTH  combinational read data from the memory
- mem_wr_en  out  1  write enable
- mem_wr_mask  out  1  equal to mem_wr_en
- mem_wr_addr  out  ADDRW  write address
- mem_wr_data  out  WIDTH  write data

## Operation
- Accept: `req_valid[i] & req_ready[i]`. The requester holds valid, write, addr, and wdata stable until accepted. Each requester has at most one request per cycle.
- Write arbiter:
  - Scan from `wr_ptr` cyclically. The first i with `req_valid[i] & req_write[i]` is granted.
  - On a grant, `wr_ptr <= (i+1) mod NREQ`. With no grant, it holds.
- Read arbiter:
  - Scan from `rd_ptr` cyclically over `req_valid[i] & ~req_write[i]`.
  - The first hit goes to port 0 and the second hit to port 1.
  - `rd_ptr <=` (index of the last granted) + 1 mod NREQ. With no grant, it holds.
- Memory drive (combinational):
  - Granted ports have enable 1 and the requester's addr/wdata.
  - Ungranted ports have enable 0 and addr/data 0.
- Response:
  - A read accepted by requester i on port p in cycle t gives `rsp_valid[i]=1` in cycle t+1 for exactly one cycle.
  - The rsp_rdata slice i is loaded with `mem_rd_datas[p]` sampled at the end of cycle t.
  - The slice holds until the next response for i.
- Same-address read and write in one cycle: the read returns the old data. A read accepted the following cycle returns the new data.
- Fairness bound: a continuously valid read is granted within ceil(NREQ/2) cycles; a continuously valid write within NREQ cycles.
- Read and write arbitration are independent. A requester's single request competes only in its own class.

## Timing
- During reset: `req_ready=0`, `mem_rd_ens=0`, `mem_wr_en=0`. All mem address/data outputs are 0 and no requests are accepted.
- Reset values: `wr_ptr=0`, `rd_ptr=0`, `rsp_valid=0`, `rsp_rdata=0`.
- req_ready and the mem_* outputs are combinational from req_* and the pointers.
- rsp_valid and rsp_rdata are registered.
- Read latency: accept in cycle t, response in cycle t+1. Back-to-back reads from one requester give consecutive rsp_valid pulses.
- Write takes effect at the memory on the clock edge ending the accept cycle.
- Reset asserted in the cycle after a read accept: rsp_valid is 0 and that response is dropped.

## Test plan
- Reset, then NREQ=4, requesters 0..3 all valid writes of addr=i, data=0x10+i. Required:
  - Grants in order 0,1,2,3 on consecutive cycles.
  - A read of addr 2 afterwards returns 0x12.
- All four read continuously with `rd_ptr=0`. Required:
  - Cycle 1 grants {0,1} (port0=0, port1=1); cycle 2 grants {2,3}; cycle 3 grants {0,1}.
  - Each rsp_valid follows its grant by exactly one cycle.
- Write addr 5 = 0xAA while another requester reads addr 5 in the same cycle (old value 0x00). Required: read returns 0x00; a read of addr 5 in the next cycle returns 0xAA.
- Only requester 3 requests a read. Required: granted on port 0 with port 1 disabled, and `rd_ptr` becomes 0.
- Assert reset one cycle after requester 1's read accept. Required: rsp_valid stays 0 and all outputs take their reset values.
- Random mixed traffic against a reference memory model. Required:
  - All read data matches the model.
  - No two ports are granted to the same requester.
  - Fairness bounds hold.
